// File: rtl/two_one_serializer.sv
// Word-to-bit serializer feeding a 2:1 mux: registered hold word and select.
// Define TWO_ONE_SER_PARITY_EN to append an even-parity beat to every frame.
module two_one_serializer #(
    parameter int W     = 2,
    parameter int SEL_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [SEL_W-1:0] sel,
    output logic [W-1:0]     hold,
    output logic             out_last
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef TWO_ONE_SER_PARITY_EN
    localparam logic [1:0] ST_PARITY = 2'd2;
`endif
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(W - 1);

    logic [1:0]       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [W-1:0]     hold_q, hold_d;
    logic             beat;
    logic             accept;

    assign out_valid = (state_q != ST_IDLE);
    assign sel       = sel_q;
    assign hold      = hold_q;

    always_comb begin
        out_bit  = 1'b0;
        out_last = 1'b0;
        if (state_q == ST_SHIFT) begin
            out_bit = hold_q[sel_q];
`ifndef TWO_ONE_SER_PARITY_EN
            out_last = (sel_q == SEL_MAX);
`endif
        end
`ifdef TWO_ONE_SER_PARITY_EN
        if (state_q == ST_PARITY) begin
            out_bit  = ^hold_q;
            out_last = 1'b1;
        end
`endif
    end

    // A new word may load in the same cycle the final beat leaves.
    assign in_ready = (state_q == ST_IDLE) || (out_valid && out_ready && out_last);
    assign beat     = out_valid && out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        if (accept) begin
            hold_d  = in_data;
            sel_d   = '0;
            state_d = ST_SHIFT;
        end else if (beat) begin
            if (out_last) begin
                state_d = ST_IDLE;
                sel_d   = '0;
            end
`ifdef TWO_ONE_SER_PARITY_EN
            else if (state_q == ST_SHIFT && sel_q == SEL_MAX) begin
                state_d = ST_PARITY;
            end
`endif
            else begin
                sel_d = sel_q + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_two_one_serializer.sv
// Self-checking bench for two_one_serializer: vector table, corner
// sequences and a randomized scoreboard run.
module tb_two_one_serializer;

    localparam int W     = 2;
    localparam int SEL_W = 1;
`ifdef TWO_ONE_SER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_bit;
    logic [SEL_W-1:0] sel;
    logic [W-1:0]     hold;
    logic             out_last;

    int n_tests = 0;
    int n_fail  = 0;

    two_one_serializer #(.W(W), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
        .sel(sel), .hold(hold), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] word;
        logic [2:0] bits;
    } vec_t;

    typedef struct {
        bit b;
        bit last;
        int s;
    } beat_t;

    beat_t exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: data bits LSB first, then even parity when enabled.
    function automatic bit exp_bit(input logic [W-1:0] w, input int k);
        if (k >= W) return ^w;
        return w[k];
    endfunction

    function automatic int exp_sel(input int k);
        return (k > W - 1) ? W - 1 : k;
    endfunction

    task automatic push_frame(input logic [W-1:0] w);
        beat_t e;
        for (int k = 0; k < FL; k++) begin
            e.b    = exp_bit(w, k);
            e.last = (k == FL - 1);
            e.s    = exp_sel(k);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vec_t tbl[4];
        logic [W-1:0] w0, w1;
        bit pend;
        beat_t e;
        int budget;

        tbl[0] = '{word: 2'b00, bits: 3'b000};
        tbl[1] = '{word: 2'b01, bits: 3'b101};
        tbl[2] = '{word: 2'b10, bits: 3'b110};
        tbl[3] = '{word: 2'b11, bits: 3'b011};

        do_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_sel", sel, 0);
        chk("rst_hold", hold, 0);
        chk("rst_bit", out_bit, 0);
        chk("rst_last", out_last, 0);
        chk("rst_in_ready", in_ready, 1);

        // Single frames from the vector table.
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_data   = tbl[i].word;
            out_ready = 1'b1;
            chk("tbl_in_ready", in_ready, 1);
            tick();
            in_valid = 1'b0;
            for (int k = 0; k < FL; k++) begin
                chk("tbl_valid", out_valid, 1);
                chk("tbl_bit", out_bit, tbl[i].bits[k]);
                chk("tbl_sel", sel, exp_sel(k));
                chk("tbl_last", out_last, (k == FL - 1) ? 1 : 0);
                tick();
            end
            chk("tbl_idle_valid", out_valid, 0);
            chk("tbl_idle_ready", in_ready, 1);
        end

        // Back-to-back frames.
        w0 = 2'b10;
        w1 = 2'b11;
        in_valid  = 1'b1;
        in_data   = w0;
        out_ready = 1'b1;
        chk("b2b_acc_ready", in_ready, 1);
        tick();
        in_data = w1;
        for (int k = 0; k < FL; k++) begin
            chk("b2b0_valid", out_valid, 1);
            chk("b2b0_bit", out_bit, exp_bit(w0, k));
            chk("b2b0_in_ready", in_ready, (k == FL - 1) ? 1 : 0);
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < FL; k++) begin
            chk("b2b1_valid", out_valid, 1);
            chk("b2b1_bit", out_bit, exp_bit(w1, k));
            chk("b2b1_sel", sel, exp_sel(k));
            chk("b2b1_in_ready", in_ready, (k == FL - 1) ? 1 : 0);
            tick();
        end
        chk("b2b_end_valid", out_valid, 0);

        // Downstream stall holds the first beat stable.
        w0 = 2'b10;
        in_valid  = 1'b1;
        in_data   = w0;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_data  = 2'b01;
        for (int c = 0; c < 3; c++) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_bit", out_bit, 0);
            chk("stall_sel", sel, 0);
            chk("stall_last", out_last, 0);
            chk("stall_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < FL; k++) begin
            chk("unstall_bit", out_bit, exp_bit(w0, k));
            chk("unstall_sel", sel, exp_sel(k));
            tick();
        end
        chk("unstall_end", out_valid, 0);

        // Reset abandons a frame after its first beat.
        in_valid  = 1'b1;
        in_data   = 2'b11;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rmid_first_bit", out_bit, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmid_valid", out_valid, 0);
        chk("rmid_sel", sel, 0);
        chk("rmid_hold", hold, 0);
        for (int c = 0; c < 4; c++) begin
            chk("rmid_no_beat", out_valid, 0);
            tick();
        end

        // Randomized traffic against the scoreboard.
        exp_q.delete();
        pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (!pend) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = W'($urandom_range(0, 3));
            end
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_bit", out_bit, e.b);
                    chk("rnd_last", out_last, e.last);
                    chk("rnd_sel", sel, e.s);
                end
            end
            if (in_valid && in_ready) begin
                push_frame(in_data);
                pend = 1'b0;
            end else begin
                pend = in_valid;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while (out_valid && budget < 20) begin
            if (exp_q.size() == 0) begin
                chk("drain_extra_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("drain_bit", out_bit, e.b);
                chk("drain_last", out_last, e.last);
            end
            tick();
            budget++;
        end
        chk("drain_timeout", (budget < 20) ? 1 : 0, 1);
        chk("drain_lost", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
